// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control path of the 16-bit pipelined CPU.
// This unit decodes the ID instruction and carries its control bits through the
// ID/EX, EX/MEM and MEM/WB registers. It also handles RAW stalls, taken-branch
// flush, memory-wait freeze with timeout, sticky halt and a saturating stall counter.
// Optional macro PIPE_CTRL_FWD_EN adds EX operand forwarding selects. With it, the
// only remaining stall is the load-use case.
module pipe_ctrl_unit #(
   parameter int unsigned  REG_AW      = 4,
   parameter int unsigned  STALL_CNT_W = 16,
   parameter int unsigned  MEM_TIMEOUT = 15,
   localparam int unsigned INSTR_W     = 4 + 3 * REG_AW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [INSTR_W-1:0]     id_instr,
   input  logic                   br_taken,
   input  logic                   mem_ready,
   output logic                   id_stall,
   output logic                   if_flush,
   output logic                   ex_valid,
   output logic                   ex_flag_wr,
   output logic                   ex_use_top,
   output logic [3:0]             ex_opc,
   output logic                   mem_en,
   output logic                   mem_wr,
   output logic                   wb_rf_wr,
   output logic [1:0]             wb_sel,
   output logic [REG_AW-1:0]      wb_rd,
`ifdef PIPE_CTRL_FWD_EN
   output logic [1:0]             fwd_a_sel,
   output logic [1:0]             fwd_b_sel,
`endif
   output logic                   halted,
   output logic                   mem_err,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

   // ID instruction fields
   logic [3:0]        id_opc;
   logic [REG_AW-1:0] id_rd, id_rs, id_rt;
   assign id_opc = id_instr[INSTR_W-1 -: 4];
   assign id_rd  = id_instr[3*REG_AW-1 -: REG_AW];
   assign id_rs  = id_instr[2*REG_AW-1 -: REG_AW];
   assign id_rt  = id_instr[REG_AW-1:0];

   // Decoded ID control
   logic       dec_rf_wr, dec_flag_wr, dec_use_top, dec_mem_en, dec_mem_wr;
   logic       dec_branch, dec_hlt, dec_use_rs, dec_use_rt, dec_use_rd;
   logic [1:0] dec_sel;

   // ID/EX register
   logic              ex_valid_q, ex_flag_wr_q, ex_use_top_q, ex_mem_en_q, ex_mem_wr_q;
   logic              ex_rf_wr_q, ex_hlt_q;
   logic [3:0]        ex_opc_q;
   logic [1:0]        ex_sel_q;
   logic [REG_AW-1:0] ex_rd_q;
`ifdef PIPE_CTRL_FWD_EN
   logic              ex_use_a_q, ex_use_b_q;
   logic [REG_AW-1:0] ex_a_q, ex_b_q;
`endif

   // EX/MEM register
   logic              mem_en_q, mem_wr_q, mem_rf_wr_q, mem_hlt_q;
   logic [1:0]        mem_sel_q;
   logic [REG_AW-1:0] mem_rd_q;

   // MEM/WB register
   logic              wb_rf_wr_q, wb_hlt_q;
   logic [1:0]        wb_sel_q;
   logic [REG_AW-1:0] wb_rd_q;

   // Status
   logic                   hlt_seen_q, halted_q, mem_err_q;
   logic [TO_W-1:0]        to_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   logic id_live, frozen, hazard, issue, ex_hit, mem_hit;

   // True when a writer of dst (register 0 excluded) feeds a source read in ID
   function automatic logic src_hit(input logic wr, input logic [REG_AW-1:0] dst,
                                    input logic u_rs, input logic [REG_AW-1:0] rs,
                                    input logic u_rt, input logic [REG_AW-1:0] rt,
                                    input logic u_rd, input logic [REG_AW-1:0] rd);
      return wr && (dst != '0) &&
             ((u_rs && dst == rs) || (u_rt && dst == rt) || (u_rd && dst == rd));
   endfunction

   // Opcode decode and source-register usage
   always_comb begin
      dec_rf_wr   = 1'b0;
      dec_sel     = 2'b00;
      dec_flag_wr = 1'b0;
      dec_use_top = 1'b0;
      dec_mem_en  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_branch  = 1'b0;
      dec_hlt     = 1'b0;
      case (id_opc)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110: begin
            dec_rf_wr   = 1'b1;
            dec_flag_wr = 1'b1;
         end
         4'b0011, 4'b0111: dec_rf_wr = 1'b1;
         4'b1000: begin
            dec_mem_en  = 1'b1;
            dec_rf_wr   = 1'b1;
            dec_sel     = 2'b01;
            dec_use_top = 1'b1;
         end
         4'b1001: begin
            dec_mem_en  = 1'b1;
            dec_mem_wr  = 1'b1;
            dec_use_top = 1'b1;
         end
         4'b1010, 4'b1011: begin
            dec_rf_wr   = 1'b1;
            dec_use_top = 1'b1;
         end
         4'b1100, 4'b1101: dec_branch = 1'b1;
         4'b1110: begin
            dec_rf_wr = 1'b1;
            dec_sel   = 2'b10;
         end
         default: dec_hlt = 1'b1;
      endcase
      dec_use_rs = !(id_opc inside {4'b1100, 4'b1010, 4'b1011, 4'b1110, 4'b1111});
      dec_use_rt = id_opc inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
      dec_use_rd = (id_opc == 4'b1001);
   end

   // Freeze, hazard, issue and flush decisions
   always_comb begin
      id_live = id_valid && !hlt_seen_q;
      frozen  = mem_en_q && !mem_ready;
      ex_hit  = src_hit(ex_rf_wr_q, ex_rd_q, dec_use_rs, id_rs, dec_use_rt, id_rt,
                        dec_use_rd, id_rd);
      mem_hit = src_hit(mem_rf_wr_q, mem_rd_q, dec_use_rs, id_rs, dec_use_rt, id_rt,
                        dec_use_rd, id_rd);
`ifdef PIPE_CTRL_FWD_EN
      // Load data is not available to forward until the LW leaves EX
      hazard  = id_live && ex_hit && ex_mem_en_q && !ex_mem_wr_q;
`else
      hazard  = id_live && (ex_hit || mem_hit);
`endif
      issue    = id_live && !hazard && !frozen;
      // HLT is issued once; PC stays held from that cycle on
      id_stall = frozen || hazard || hlt_seen_q || (id_valid && dec_hlt);
      if_flush = issue && dec_branch && br_taken;
   end

   // ID/EX register: hold on freeze, bubble when nothing issues
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q   <= 1'b0;
         ex_opc_q     <= '0;
         ex_flag_wr_q <= 1'b0;
         ex_use_top_q <= 1'b0;
         ex_mem_en_q  <= 1'b0;
         ex_mem_wr_q  <= 1'b0;
         ex_rf_wr_q   <= 1'b0;
         ex_sel_q     <= '0;
         ex_rd_q      <= '0;
         ex_hlt_q     <= 1'b0;
`ifdef PIPE_CTRL_FWD_EN
         ex_use_a_q   <= 1'b0;
         ex_use_b_q   <= 1'b0;
         ex_a_q       <= '0;
         ex_b_q       <= '0;
`endif
      end else if (!frozen) begin
         ex_valid_q   <= issue;
         ex_opc_q     <= issue ? id_opc : 4'b0000;
         ex_flag_wr_q <= issue && dec_flag_wr;
         ex_use_top_q <= issue && dec_use_top;
         ex_mem_en_q  <= issue && dec_mem_en;
         ex_mem_wr_q  <= issue && dec_mem_wr;
         ex_rf_wr_q   <= issue && dec_rf_wr;
         ex_sel_q     <= issue ? dec_sel : 2'b00;
         ex_rd_q      <= issue ? id_rd : '0;
         ex_hlt_q     <= issue && dec_hlt;
`ifdef PIPE_CTRL_FWD_EN
         // Operand B carries the store data register for SW
         ex_use_a_q   <= issue && dec_use_rs;
         ex_use_b_q   <= issue && (dec_use_rt || dec_use_rd);
         ex_a_q       <= issue ? id_rs : '0;
         ex_b_q       <= issue ? (dec_use_rd ? id_rd : id_rt) : '0;
`endif
      end
   end

   // EX/MEM register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_rf_wr_q <= 1'b0;
         mem_sel_q   <= '0;
         mem_rd_q    <= '0;
         mem_hlt_q   <= 1'b0;
      end else if (!frozen) begin
         mem_en_q    <= ex_mem_en_q;
         mem_wr_q    <= ex_mem_wr_q;
         mem_rf_wr_q <= ex_rf_wr_q;
         mem_sel_q   <= ex_sel_q;
         mem_rd_q    <= ex_rd_q;
         mem_hlt_q   <= ex_hlt_q;
      end
   end

   // MEM/WB register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rf_wr_q <= 1'b0;
         wb_sel_q   <= '0;
         wb_rd_q    <= '0;
         wb_hlt_q   <= 1'b0;
      end else if (!frozen) begin
         wb_rf_wr_q <= mem_rf_wr_q;
         wb_sel_q   <= mem_sel_q;
         wb_rd_q    <= mem_rd_q;
         wb_hlt_q   <= mem_hlt_q;
      end
   end

   assign halted = halted_q || wb_hlt_q;

   // Sticky status, freeze timeout and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hlt_seen_q  <= 1'b0;
         halted_q    <= 1'b0;
         mem_err_q   <= 1'b0;
         to_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (issue && dec_hlt) hlt_seen_q <= 1'b1;
         if (wb_hlt_q) halted_q <= 1'b1;
         if (frozen) begin
            if (to_cnt_q == TO_W'(MEM_TIMEOUT - 1)) mem_err_q <= 1'b1;
            if (to_cnt_q != TO_W'(MEM_TIMEOUT)) to_cnt_q <= to_cnt_q + 1'b1;
         end else begin
            to_cnt_q <= '0;
         end
         if (id_stall && !halted && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

`ifdef PIPE_CTRL_FWD_EN
   // Operand forwarding: the younger producer in MEM wins over WB
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (ex_use_a_q && ex_a_q != '0) begin
         if (mem_rf_wr_q && mem_rd_q == ex_a_q)     fwd_a_sel = 2'b01;
         else if (wb_rf_wr_q && wb_rd_q == ex_a_q)  fwd_a_sel = 2'b10;
      end
      if (ex_use_b_q && ex_b_q != '0) begin
         if (mem_rf_wr_q && mem_rd_q == ex_b_q)     fwd_b_sel = 2'b01;
         else if (wb_rf_wr_q && wb_rd_q == ex_b_q)  fwd_b_sel = 2'b10;
      end
   end
`endif

   assign ex_valid   = ex_valid_q;
   assign ex_flag_wr = ex_flag_wr_q;
   assign ex_use_top = ex_use_top_q;
   assign ex_opc     = ex_opc_q;
   assign mem_en     = mem_en_q;
   assign mem_wr     = mem_wr_q;
   assign wb_rf_wr   = wb_rf_wr_q;
   assign wb_sel     = wb_sel_q;
   assign wb_rd      = wb_rd_q;
   assign mem_err    = mem_err_q;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit against an instruction-level pipeline model.
// The bench acts as the fetch stage: it holds the ID word while stalled and
// inserts a bubble after a flush. The counter width is shrunk so that saturation
// can be reached.
module tb_pipe_ctrl_unit;
   localparam int unsigned REG_AW      = 4;
   localparam int unsigned INSTR_W     = 4 + 3 * REG_AW;
   localparam int unsigned CNT_W       = 6;
   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int          NCYC        = 3000;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               id_valid = 1'b0;
   logic [INSTR_W-1:0] id_instr = '0;
   logic               br_taken = 1'b0;
   logic               mem_ready = 1'b1;
   logic               id_stall, if_flush, ex_valid, ex_flag_wr, ex_use_top;
   logic [3:0]         ex_opc;
   logic               mem_en, mem_wr, wb_rf_wr, halted, mem_err;
   logic [1:0]         wb_sel;
   logic [REG_AW-1:0]  wb_rd;
   logic [CNT_W-1:0]   stall_cnt;
`ifdef PIPE_CTRL_FWD_EN
   logic [1:0]         fwd_a_sel, fwd_b_sel;
`endif

   pipe_ctrl_unit #(
      .REG_AW(REG_AW), .STALL_CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .br_taken(br_taken), .mem_ready(mem_ready), .id_stall(id_stall),
      .if_flush(if_flush), .ex_valid(ex_valid), .ex_flag_wr(ex_flag_wr),
      .ex_use_top(ex_use_top), .ex_opc(ex_opc), .mem_en(mem_en), .mem_wr(mem_wr),
      .wb_rf_wr(wb_rf_wr), .wb_sel(wb_sel), .wb_rd(wb_rd),
`ifdef PIPE_CTRL_FWD_EN
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
`endif
      .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction-level helpers
   function automatic logic [3:0] opc_of(input logic [INSTR_W-1:0] i);
      return i[INSTR_W-1 -: 4];
   endfunction
   function automatic logic [REG_AW-1:0] rd_of(input logic [INSTR_W-1:0] i);
      return i[3*REG_AW-1 -: REG_AW];
   endfunction
   function automatic logic [REG_AW-1:0] rs_of(input logic [INSTR_W-1:0] i);
      return i[2*REG_AW-1 -: REG_AW];
   endfunction
   function automatic logic [REG_AW-1:0] rt_of(input logic [INSTR_W-1:0] i);
      return i[REG_AW-1:0];
   endfunction
   function automatic bit writes_rf(input logic [3:0] op);
      return !(op inside {4'd9, 4'd12, 4'd13, 4'd15});
   endfunction
   function automatic bit uses_rs(input logic [3:0] op);
      return !(op inside {4'd10, 4'd11, 4'd12, 4'd14, 4'd15});
   endfunction
   function automatic bit uses_rt(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
   endfunction
   function automatic bit reads_reg(input logic [INSTR_W-1:0] i, input logic [REG_AW-1:0] r);
      logic [3:0] op;
      op = opc_of(i);
      if (r == '0) return 1'b0;
      return (uses_rs(op) && rs_of(i) == r) || (uses_rt(op) && rt_of(i) == r) ||
             (op == 4'd9 && rd_of(i) == r);
   endfunction
   function automatic logic [1:0] sel_of(input logic [3:0] op);
      return (op == 4'd8) ? 2'b01 : ((op == 4'd14) ? 2'b10 : 2'b00);
   endfunction

   // Model state: index 0 = EX, 1 = MEM, 2 = WB
   logic [INSTR_W-1:0] m_ins [3];
   bit                 m_v [3];
   bit                 m_hlt_seen, m_halted, m_err;
   int                 m_fcnt;
   int unsigned        m_scnt;

   // Fetch side
   logic [INSTR_W-1:0] dq [$];
   logic [INSTR_W-1:0] cur_instr;
   logic               cur_valid;
   int                 low_cnt = 0;

   bit e_frozen, e_haz, e_issue, e_stall, e_flush, e_halted;

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_v[k]   = 1'b0;
         m_ins[k] = '0;
      end
      m_hlt_seen = 1'b0;
      m_halted   = 1'b0;
      m_err      = 1'b0;
      m_fcnt     = 0;
      m_scnt     = 0;
   endtask

   task automatic fetch_next();
      logic [3:0] op;
      if (dq.size() > 0) begin
         cur_instr = dq.pop_front();
         cur_valid = 1'b1;
      end else begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 11) != 0) op = 4'($urandom_range(0, 14));
         cur_instr = {op, REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                      REG_AW'($urandom_range(0, 3))};
         cur_valid = ($urandom_range(0, 7) != 0);
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      id_valid = 1'b0;
      br_taken = 1'b0;
      #1;
      check("rst_id_stall", 32'(id_stall), 32'(0));
      check("rst_if_flush", 32'(if_flush), 32'(0));
      check("rst_ex_valid", 32'(ex_valid), 32'(0));
      check("rst_ex_opc", 32'(ex_opc), 32'(0));
      check("rst_mem_en", 32'(mem_en), 32'(0));
      check("rst_wb_rf_wr", 32'(wb_rf_wr), 32'(0));
      check("rst_wb_sel", 32'(wb_sel), 32'(0));
      check("rst_halted", 32'(halted), 32'(0));
      check("rst_mem_err", 32'(mem_err), 32'(0));
      check("rst_stall_cnt", 32'(stall_cnt), 32'(0));
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      low_cnt = 0;
      fetch_next();
   endtask

`ifdef PIPE_CTRL_FWD_EN
   function automatic logic [1:0] fwd_for(input bit used, input logic [REG_AW-1:0] r);
      if (!used || r == '0) return 2'b00;
      if (m_v[1] && writes_rf(opc_of(m_ins[1])) && rd_of(m_ins[1]) == r) return 2'b01;
      if (m_v[2] && writes_rf(opc_of(m_ins[2])) && rd_of(m_ins[2]) == r) return 2'b10;
      return 2'b00;
   endfunction
`endif

   task automatic eval_and_check();
      logic [3:0] op0, op1, op2, opid;
      op0  = opc_of(m_ins[0]);
      op1  = opc_of(m_ins[1]);
      op2  = opc_of(m_ins[2]);
      opid = opc_of(id_instr);
      e_frozen = m_v[1] && (op1 inside {4'd8, 4'd9}) && !mem_ready;
      e_haz = 1'b0;
      if (id_valid && !m_hlt_seen) begin
`ifdef PIPE_CTRL_FWD_EN
         if (m_v[0] && op0 == 4'd8 && reads_reg(id_instr, rd_of(m_ins[0]))) e_haz = 1'b1;
`else
         for (int k = 0; k < 2; k++)
            if (m_v[k] && writes_rf(opc_of(m_ins[k])) && reads_reg(id_instr, rd_of(m_ins[k])))
               e_haz = 1'b1;
`endif
      end
      e_issue  = id_valid && !m_hlt_seen && !e_haz && !e_frozen;
      e_stall  = e_frozen || e_haz || m_hlt_seen || (id_valid && opid == 4'd15);
      e_flush  = e_issue && (opid inside {4'd12, 4'd13}) && br_taken;
      e_halted = m_halted || (m_v[2] && op2 == 4'd15);

      check("id_stall", 32'(id_stall), 32'(e_stall));
      check("if_flush", 32'(if_flush), 32'(e_flush));
      check("ex_valid", 32'(ex_valid), 32'(m_v[0]));
      check("ex_opc", 32'(ex_opc), m_v[0] ? 32'(op0) : 32'(0));
      check("ex_flag_wr", 32'(ex_flag_wr),
            32'(m_v[0] && (op0 inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6})));
      check("ex_use_top", 32'(ex_use_top), 32'(m_v[0] && (op0 inside {[4'd8:4'd11]})));
      check("mem_en", 32'(mem_en), 32'(m_v[1] && (op1 inside {4'd8, 4'd9})));
      check("mem_wr", 32'(mem_wr), 32'(m_v[1] && op1 == 4'd9));
      check("wb_rf_wr", 32'(wb_rf_wr), 32'(m_v[2] && writes_rf(op2)));
      check("wb_sel", 32'(wb_sel), m_v[2] ? 32'(sel_of(op2)) : 32'(0));
      check("wb_rd", 32'(wb_rd), m_v[2] ? 32'(rd_of(m_ins[2])) : 32'(0));
      check("halted", 32'(halted), 32'(e_halted));
      check("mem_err", 32'(mem_err), 32'(m_err));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`ifdef PIPE_CTRL_FWD_EN
      check("fwd_a_sel", 32'(fwd_a_sel), 32'(fwd_for(m_v[0] && uses_rs(op0), rs_of(m_ins[0]))));
      check("fwd_b_sel", 32'(fwd_b_sel),
            32'(fwd_for(m_v[0] && (uses_rt(op0) || op0 == 4'd9),
                        (op0 == 4'd9) ? rd_of(m_ins[0]) : rt_of(m_ins[0]))));
`endif
   endtask

   task automatic model_step();
      if (e_frozen) begin
         m_fcnt++;
         if (m_fcnt >= int'(MEM_TIMEOUT)) m_err = 1'b1;
      end else begin
         m_fcnt = 0;
      end
      if (e_stall && !e_halted && m_scnt < (2 ** CNT_W) - 1) m_scnt++;
      if (e_halted) m_halted = 1'b1;
      if (!e_frozen) begin
         m_ins[2] = m_ins[1];
         m_v[2]   = m_v[1];
         m_ins[1] = m_ins[0];
         m_v[1]   = m_v[0];
         m_ins[0] = id_instr;
         m_v[0]   = e_issue;
      end
      if (e_issue && opc_of(id_instr) == 4'd15) m_hlt_seen = 1'b1;
      if (!e_stall) begin
         if (e_flush) cur_valid = 1'b0;
         else fetch_next();
      end
   endtask

   initial begin
      int next_rst;
      next_rst = 0;
      model_reset();
      // ADD r1,r2,r3 ; SUB r2,r1,r3 ; LW r4 ; ADD r5,r4,r4 ; B taken-able
      dq.push_back({4'h0, 4'd1, 4'd2, 4'd3});
      dq.push_back({4'h1, 4'd2, 4'd1, 4'd3});
      dq.push_back({4'h8, 4'd4, 4'd1, 4'd0});
      dq.push_back({4'h0, 4'd5, 4'd4, 4'd4});
      dq.push_back({4'hC, 4'd0, 4'd0, 4'd0});
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         if (cyc == next_rst) begin
            do_reset();
            next_rst = cyc + $urandom_range(100, 300);
         end
         id_valid = cur_valid;
         id_instr = cur_instr;
         br_taken = ($urandom_range(0, 1) != 0);
         if (low_cnt > 0) begin
            mem_ready = 1'b0;
            low_cnt--;
         end else begin
            if ($urandom_range(0, 39) == 0) low_cnt = $urandom_range(10, 20);
            mem_ready = ($urandom_range(0, 3) != 0);
         end
         #1;
         eval_and_check();
         @(posedge clk);
         model_step();
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
